// File: rtl/sdram_work_sched_if.sv
// Request/strobe bundle between the SDRAM work sequencer and the write/read datapaths
// and the command-generation block.
interface sdram_work_sched_if;
    logic       init_done;
    logic       wr_req;
    logic       rd_req;
    logic       wr_ack;
    logic       rd_ack;
    logic       wr_data_en;
    logic       rd_data_valid;
    logic       wr_done;
    logic       rd_done;
    logic [3:0] work_state;
    logic       busy;
    logic       ref_miss;

    modport master (
        output init_done, wr_req, rd_req,
        input  wr_ack, rd_ack, wr_data_en, rd_data_valid, wr_done, rd_done,
               work_state, busy, ref_miss
    );

    modport slave (
        input  init_done, wr_req, rd_req,
        output wr_ack, rd_ack, wr_data_en, rd_data_valid, wr_done, rd_done,
               work_state, busy, ref_miss
    );
endinterface

// File: rtl/sdram_work_sched.sv
// SDRAM post-init work sequencer: refresh/write/read arbitration, burst timing, data strobes.
// Build option RD_FAIR_EN: round-robin between write and read when both are pending.
//
// state       | meaning
// W_IDLE      | waiting; arbitrates when init_done
// W_ACTIVE_r  | ACTIVE for a read, rd_ack pulse
// W_ACTIVE_w  | ACTIVE for a write, wr_ack pulse
// W_TRCD      | ACTIVE-to-column spacing
// W_READ      | READ command
// W_CL        | CAS latency drain after read burst stop
// W_RD        | read burst running
// W_B_R_STOP  | burst stop after a read
// W_WRITE     | WRITE command, first data word
// W_WD        | write burst running
// W_B_W_STOP  | burst stop after a write
// W_TDAL      | write recovery plus precharge
// W_AR        | AUTO REFRESH command
// W_TRFC      | refresh recovery
module sdram_work_sched #(
    parameter int REF_PERIOD = 780,
    parameter int TRCD       = 3,
    parameter int CL         = 3,
    parameter int TRFC       = 7,
    parameter int TDAL       = 4,
    parameter int BURST_LEN  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    sdram_work_sched_if.slave  bus
);

    typedef enum logic [3:0] {
        W_IDLE     = 4'd0,
        W_ACTIVE_r = 4'd1,
        W_ACTIVE_w = 4'd2,
        W_TRCD     = 4'd3,
        W_READ     = 4'd4,
        W_CL       = 4'd5,
        W_RD       = 4'd6,
        W_B_R_STOP = 4'd7,
        W_WRITE    = 4'd8,
        W_WD       = 4'd9,
        W_B_W_STOP = 4'd10,
        W_TDAL     = 4'd11,
        W_AR       = 4'd12,
        W_TRFC     = 4'd13
    } work_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_WAIT = imax(imax(BURST_LEN, TRFC), imax(imax(TDAL, CL), TRCD));
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam int REF_W    = $clog2(REF_PERIOD + 1);

    // Each multi-cycle state of N cycles is entered with N-1 loaded and leaves at 0.
    // The read-valid window needs 1 <= CL <= BURST_LEN-2.
    localparam logic [CNT_W-1:0] LD_TRCD   = CNT_W'(TRCD - 2);
    localparam logic [CNT_W-1:0] LD_BURST  = CNT_W'(BURST_LEN - 2);
    localparam logic [CNT_W-1:0] LD_CL     = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] LD_TRFC   = CNT_W'(TRFC - 1);
    localparam logic [CNT_W-1:0] LD_TDAL   = CNT_W'(TDAL - 1);
    localparam logic [CNT_W-1:0] RDV_START = CNT_W'(BURST_LEN - 1 - CL);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_PERIOD - 1);

    work_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_miss_r;
    logic             is_rd;
    logic             wr_ack_r;
    logic             rd_ack_r;
    logic             wr_data_en_r;
    logic             rd_data_valid_r;
    logic             wr_done_r;
    logic             rd_done_r;
    logic             grant_wr;
    logic             grant_rd;

`ifdef RD_FAIR_EN
    logic prio_wr;
    assign grant_wr = bus.wr_req && (!bus.rd_req || prio_wr);
`else
    assign grant_wr = bus.wr_req;
`endif
    assign grant_rd = bus.rd_req && !grant_wr;

    // A wrap landing in the W_AR cycle re-arms the pending flag without counting a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
            ref_miss_r  <= 1'b0;
        end else begin
            ref_miss_r <= 1'b0;
            if (!bus.init_done) begin
                ref_cnt <= '0;
            end else if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            if (bus.init_done && (ref_cnt == REF_LAST)) begin
                if (ref_pending && (state != W_AR)) begin
                    ref_miss_r <= 1'b1;
                end
                ref_pending <= 1'b1;
            end else if (state == W_AR) begin
                ref_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= W_IDLE;
            cnt             <= '0;
            is_rd           <= 1'b0;
            wr_ack_r        <= 1'b0;
            rd_ack_r        <= 1'b0;
            wr_data_en_r    <= 1'b0;
            rd_data_valid_r <= 1'b0;
            wr_done_r       <= 1'b0;
            rd_done_r       <= 1'b0;
`ifdef RD_FAIR_EN
            prio_wr         <= 1'b1;
`endif
        end else begin
            wr_ack_r  <= 1'b0;
            rd_ack_r  <= 1'b0;
            wr_done_r <= 1'b0;
            rd_done_r <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (bus.init_done) begin
                        if (ref_pending) begin
                            state <= W_AR;
                        end else if (grant_wr) begin
                            state    <= W_ACTIVE_w;
                            wr_ack_r <= 1'b1;
                            is_rd    <= 1'b0;
`ifdef RD_FAIR_EN
                            prio_wr  <= 1'b0;
`endif
                        end else if (grant_rd) begin
                            state    <= W_ACTIVE_r;
                            rd_ack_r <= 1'b1;
                            is_rd    <= 1'b1;
`ifdef RD_FAIR_EN
                            prio_wr  <= 1'b1;
`endif
                        end
                    end
                end
                W_ACTIVE_r, W_ACTIVE_w: begin
                    state <= W_TRCD;
                    cnt   <= LD_TRCD;
                end
                W_TRCD: begin
                    if (cnt == '0) begin
                        if (is_rd) begin
                            state <= W_READ;
                        end else begin
                            state        <= W_WRITE;
                            wr_data_en_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                W_WRITE: begin
                    state <= W_WD;
                    cnt   <= LD_BURST;
                end
                W_WD: begin
                    if (cnt == '0) begin
                        state        <= W_B_W_STOP;
                        wr_data_en_r <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                W_B_W_STOP: begin
                    state     <= W_TDAL;
                    cnt       <= LD_TDAL;
                    wr_done_r <= (LD_TDAL == '0);
                end
                W_READ: begin
                    state <= W_RD;
                    cnt   <= LD_BURST;
                end
                W_RD: begin
                    // Data lands CL cycles after the command register, so the valid
                    // window opens mid-burst and closes at the end of W_CL.
                    if (cnt == RDV_START) begin
                        rd_data_valid_r <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= W_B_R_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                W_B_R_STOP: begin
                    state <= W_CL;
                    cnt   <= LD_CL;
                end
                W_CL: begin
                    if (cnt == '0) begin
                        state           <= W_TDAL;
                        cnt             <= LD_TDAL;
                        rd_data_valid_r <= 1'b0;
                        rd_done_r       <= (LD_TDAL == '0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                W_TDAL: begin
                    if (cnt == '0) begin
                        state <= W_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            wr_done_r <= !is_rd;
                            rd_done_r <= is_rd;
                        end
                    end
                end
                W_AR: begin
                    state <= W_TRFC;
                    cnt   <= LD_TRFC;
                end
                W_TRFC: begin
                    if (cnt == '0) begin
                        state <= W_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state           <= W_IDLE;
                    wr_data_en_r    <= 1'b0;
                    rd_data_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.work_state    = state;
    assign bus.busy          = (state != W_IDLE);
    assign bus.wr_ack        = wr_ack_r;
    assign bus.rd_ack        = rd_ack_r;
    assign bus.wr_data_en    = wr_data_en_r;
    assign bus.rd_data_valid = rd_data_valid_r;
    assign bus.wr_done       = wr_done_r;
    assign bus.rd_done       = rd_done_r;
    assign bus.ref_miss      = ref_miss_r;

endmodule

// File: tb/tb_sdram_work_sched.sv
// Directed bench for sdram_work_sched: default instance plus a REF_PERIOD=100 instance for refresh misses.
module tb_sdram_work_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_s;
    int   n_checks = 0;
    int   n_pass = 0;

    sdram_work_sched_if bus();
    sdram_work_sched_if bus_s();

    sdram_work_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    sdram_work_sched #(.REF_PERIOD(100)) dut_s (
        .clk   (clk),
        .rst_n (rst_n_s),
        .bus   (bus_s.slave)
    );

    always #5 clk = ~clk;

`ifdef RD_FAIR_EN
    localparam logic [3:0] B2B_S1 = 4'd1;
    localparam int         B2B_T2 = 533;
`else
    localparam logic [3:0] B2B_S1 = 4'd2;
    localparam int         B2B_T2 = 530;
`endif

    task automatic reset_main();
        rst_n         = 1'b0;
        bus.init_done = 1'b0;
        bus.wr_req    = 1'b0;
        bus.rd_req    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int idle_cnt = 0;
        int ack_cnt = 0;
        rst_n = 1'b0;
        bus.init_done = 1'b0;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.work_state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", bus.work_state); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if ({bus.wr_ack, bus.rd_ack, bus.wr_done, bus.rd_done} !== 4'b0) $display("FAIL reset_pulses: got %b expected 0000", {bus.wr_ack, bus.rd_ack, bus.wr_done, bus.rd_done}); else n_pass++;
        n_checks++; if ({bus.wr_data_en, bus.rd_data_valid, bus.ref_miss} !== 3'b0) $display("FAIL reset_strobes: got %b expected 000", {bus.wr_data_en, bus.rd_data_valid, bus.ref_miss}); else n_pass++;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.work_state == 4'd0) idle_cnt++;
            if (bus.wr_ack || bus.rd_ack) ack_cnt++;
        end
        n_checks++; if (idle_cnt !== 20) $display("FAIL no_init_idle: got %0d idle cycles expected 20", idle_cnt); else n_pass++;
        n_checks++; if (ack_cnt !== 0) $display("FAIL no_init_ack: got %0d acks expected 0", ack_cnt); else n_pass++;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_refresh();
        int ar_cnt = 0;
        int ar0 = -1;
        int ar1 = -1;
        int trfc_cyc = 0;
        int miss = 0;
        reset_main();
        bus.init_done = 1'b1;
        for (int n = 0; n < 1580; n++) begin
            @(negedge clk);
            if (bus.work_state == 4'd12) begin
                if (ar_cnt == 0) ar0 = n;
                else if (ar_cnt == 1) ar1 = n;
                ar_cnt++;
            end
            if (bus.work_state == 4'd13) trfc_cyc++;
            if (bus.ref_miss) miss++;
        end
        n_checks++; if (ar_cnt !== 2) $display("FAIL refresh_count: got %0d expected 2", ar_cnt); else n_pass++;
        n_checks++; if (ar0 !== 780) $display("FAIL refresh_first_ar: got %0d expected 780", ar0); else n_pass++;
        n_checks++; if (ar1 !== 1560) $display("FAIL refresh_second_ar: got %0d expected 1560", ar1); else n_pass++;
        n_checks++; if (trfc_cyc !== 14) $display("FAIL refresh_trfc_len: got %0d expected 14", trfc_cyc); else n_pass++;
        n_checks++; if (miss !== 0) $display("FAIL refresh_no_miss: got %0d expected 0", miss); else n_pass++;
    endtask

    task automatic test_write();
        int ack_at = -1, ack_cnt = 0, wr_at = -1, stop_at = -1;
        int en_first = -1, en_last = -1, en_cnt = 0;
        int done_at = -1, done_cnt = 0, idle_at = -1, busy_cnt = 0, rdv_cnt = 0;
        reset_main();
        bus.init_done = 1'b1;
        bus.wr_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.wr_ack) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = n;
                bus.wr_req = 1'b0;
            end
            if (bus.work_state == 4'd8 && wr_at < 0) wr_at = n;
            if (bus.work_state == 4'd10 && stop_at < 0) stop_at = n;
            if (bus.wr_data_en) begin
                if (en_first < 0) en_first = n;
                en_last = n;
                en_cnt++;
            end
            if (bus.wr_done) begin
                done_cnt++;
                done_at = n;
            end
            if (bus.busy) busy_cnt++;
            if (bus.rd_data_valid) rdv_cnt++;
            if (ack_at >= 0 && bus.work_state == 4'd0 && idle_at < 0) idle_at = n;
        end
        n_checks++; if (ack_at !== 0 || ack_cnt !== 1) $display("FAIL wr_ack: got at %0d count %0d expected at 0 count 1", ack_at, ack_cnt); else n_pass++;
        n_checks++; if (wr_at !== 3) $display("FAIL wr_write_state: got %0d expected 3", wr_at); else n_pass++;
        n_checks++; if (en_first !== 3 || en_last !== 258) $display("FAIL wr_data_en_window: got %0d..%0d expected 3..258", en_first, en_last); else n_pass++;
        n_checks++; if (en_cnt !== 256) $display("FAIL wr_data_en_len: got %0d expected 256", en_cnt); else n_pass++;
        n_checks++; if (stop_at !== 259) $display("FAIL wr_burst_stop: got %0d expected 259", stop_at); else n_pass++;
        n_checks++; if (done_at !== 263 || done_cnt !== 1) $display("FAIL wr_done: got at %0d count %0d expected at 263 count 1", done_at, done_cnt); else n_pass++;
        n_checks++; if (idle_at !== 264) $display("FAIL wr_return_idle: got %0d expected 264", idle_at); else n_pass++;
        n_checks++; if (busy_cnt !== 264) $display("FAIL wr_busy_len: got %0d expected 264", busy_cnt); else n_pass++;
        n_checks++; if (rdv_cnt !== 0) $display("FAIL wr_no_rd_valid: got %0d expected 0", rdv_cnt); else n_pass++;
    endtask

    task automatic test_read();
        int ack_at = -1, rd_at = -1, stop_at = -1, cl_first = -1, cl_cnt = 0;
        int v_first = -1, v_last = -1, v_cnt = 0;
        int done_at = -1, done_cnt = 0, idle_at = -1, en_cnt = 0;
        reset_main();
        bus.init_done = 1'b1;
        bus.rd_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.rd_ack) begin
                if (ack_at < 0) ack_at = n;
                bus.rd_req = 1'b0;
            end
            if (bus.work_state == 4'd4 && rd_at < 0) rd_at = n;
            if (bus.work_state == 4'd7 && stop_at < 0) stop_at = n;
            if (bus.work_state == 4'd5) begin
                if (cl_first < 0) cl_first = n;
                cl_cnt++;
            end
            if (bus.rd_data_valid) begin
                if (v_first < 0) v_first = n;
                v_last = n;
                v_cnt++;
            end
            if (bus.rd_done) begin
                done_cnt++;
                done_at = n;
            end
            if (bus.wr_data_en) en_cnt++;
            if (ack_at >= 0 && bus.work_state == 4'd0 && idle_at < 0) idle_at = n;
        end
        n_checks++; if (ack_at !== 0) $display("FAIL rd_ack: got %0d expected 0", ack_at); else n_pass++;
        n_checks++; if (rd_at !== 3) $display("FAIL rd_read_state: got %0d expected 3", rd_at); else n_pass++;
        n_checks++; if (v_first !== 7 || v_last !== 262 || v_cnt !== 256) $display("FAIL rd_valid_window: got %0d..%0d (%0d) expected 7..262 (256)", v_first, v_last, v_cnt); else n_pass++;
        n_checks++; if (stop_at !== 259) $display("FAIL rd_burst_stop: got %0d expected 259", stop_at); else n_pass++;
        n_checks++; if (cl_first !== 260 || cl_cnt !== 3) $display("FAIL rd_cl: got start %0d len %0d expected start 260 len 3", cl_first, cl_cnt); else n_pass++;
        n_checks++; if (done_at !== 266 || done_cnt !== 1) $display("FAIL rd_done: got at %0d count %0d expected at 266 count 1", done_at, done_cnt); else n_pass++;
        n_checks++; if (idle_at !== 267) $display("FAIL rd_return_idle: got %0d expected 267", idle_at); else n_pass++;
        n_checks++; if (en_cnt !== 0) $display("FAIL rd_no_wr_en: got %0d expected 0", en_cnt); else n_pass++;
    endtask

    task automatic test_priority();
        int g_cnt = 0;
        int g_t[3];
        logic [3:0] g_s[3];
        for (int i = 0; i < 3; i++) begin
            g_t[i] = -1;
            g_s[i] = 4'd0;
        end
        reset_main();
        bus.init_done = 1'b1;
        for (int n = 0; n < 1400; n++) begin
            @(negedge clk);
            if (bus.work_state == 4'd1 || bus.work_state == 4'd2 || bus.work_state == 4'd12) begin
                if (g_cnt < 3) begin
                    g_t[g_cnt] = n;
                    g_s[g_cnt] = bus.work_state;
                end
                g_cnt++;
            end
            if (bus.wr_ack) bus.wr_req = 1'b0;
            if (bus.rd_ack) bus.rd_req = 1'b0;
            if (n == 779) begin
                bus.wr_req = 1'b1;
                bus.rd_req = 1'b1;
            end
        end
        n_checks++; if (g_cnt !== 3) $display("FAIL prio_grant_count: got %0d expected 3", g_cnt); else n_pass++;
        n_checks++; if (g_s[0] !== 4'd12 || g_t[0] !== 780) $display("FAIL prio_first_ar: got state %0d at %0d expected 12 at 780", g_s[0], g_t[0]); else n_pass++;
        n_checks++; if (g_s[1] !== 4'd2 || g_t[1] !== 789) $display("FAIL prio_second_wr: got state %0d at %0d expected 2 at 789", g_s[1], g_t[1]); else n_pass++;
        n_checks++; if (g_s[2] !== 4'd1 || g_t[2] !== 1054) $display("FAIL prio_third_rd: got state %0d at %0d expected 1 at 1054", g_s[2], g_t[2]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int g_cnt = 0;
        int g_t[3];
        logic [3:0] g_s[3];
        for (int i = 0; i < 3; i++) begin
            g_t[i] = -1;
            g_s[i] = 4'd0;
        end
        reset_main();
        bus.init_done = 1'b1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (bus.work_state == 4'd1 || bus.work_state == 4'd2) begin
                if (g_cnt < 3) begin
                    g_t[g_cnt] = n;
                    g_s[g_cnt] = bus.work_state;
                end
                g_cnt++;
            end
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        n_checks++; if (g_s[0] !== 4'd2 || g_t[0] !== 0) $display("FAIL b2b_first: got state %0d at %0d expected 2 at 0", g_s[0], g_t[0]); else n_pass++;
        n_checks++; if (g_s[1] !== B2B_S1 || g_t[1] !== 265) $display("FAIL b2b_second: got state %0d at %0d expected %0d at 265", g_s[1], g_t[1], B2B_S1); else n_pass++;
        n_checks++; if (g_s[2] !== 4'd2 || g_t[2] !== B2B_T2) $display("FAIL b2b_third: got state %0d at %0d expected 2 at %0d", g_s[2], g_t[2], B2B_T2); else n_pass++;
    endtask

    task automatic test_ref_miss();
        int miss_cnt = 0, miss_at = -1, ar_cnt = 0, ar_at = -1, ack_cnt = 0, ack2_at = -1;
        rst_n_s = 1'b0;
        bus_s.init_done = 1'b0;
        bus_s.wr_req = 1'b0;
        bus_s.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_s = 1'b1;
        @(negedge clk);
        bus_s.init_done = 1'b1;
        bus_s.wr_req = 1'b1;
        for (int n = 0; n < 350; n++) begin
            @(negedge clk);
            if (bus_s.ref_miss) begin
                miss_cnt++;
                if (miss_at < 0) miss_at = n;
            end
            if (bus_s.work_state == 4'd12) begin
                ar_cnt++;
                if (ar_at < 0) ar_at = n;
            end
            if (bus_s.wr_ack) begin
                ack_cnt++;
                if (ack_cnt == 2) begin
                    ack2_at = n;
                    bus_s.wr_req = 1'b0;
                end
            end
        end
        n_checks++; if (miss_cnt !== 1 || miss_at !== 199) $display("FAIL miss_pulse: got %0d pulses first at %0d expected 1 at 199", miss_cnt, miss_at); else n_pass++;
        n_checks++; if (ar_cnt !== 1 || ar_at !== 265) $display("FAIL miss_single_refresh: got %0d refreshes first at %0d expected 1 at 265", ar_cnt, ar_at); else n_pass++;
        n_checks++; if (ack_cnt !== 2 || ack2_at !== 274) $display("FAIL miss_second_write: got %0d acks second at %0d expected 2 at 274", ack_cnt, ack2_at); else n_pass++;
        rst_n_s = 1'b0;
        bus_s.init_done = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int wr_at = -1, en_at = -1;
        logic [3:0] st_before = 4'd0;
        logic en_before = 1'b0;
        reset_main();
        bus.init_done = 1'b1;
        bus.wr_req = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.wr_ack) bus.wr_req = 1'b0;
        end
        st_before = bus.work_state;
        en_before = bus.wr_data_en;
        rst_n = 1'b0;
        #1;
        n_checks++; if (st_before !== 4'd9 || en_before !== 1'b1) $display("FAIL midrst_precond: got state %0d en %b expected 9 1", st_before, en_before); else n_pass++;
        n_checks++; if (bus.work_state !== 4'd0 || bus.busy !== 1'b0) $display("FAIL midrst_state: got %0d busy %b expected 0 0", bus.work_state, bus.busy); else n_pass++;
        n_checks++; if (bus.wr_data_en !== 1'b0) $display("FAIL midrst_wr_en: got %b expected 0", bus.wr_data_en); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.wr_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.wr_ack) bus.wr_req = 1'b0;
            if (bus.work_state == 4'd8 && wr_at < 0) wr_at = n;
            if (bus.wr_data_en && en_at < 0) en_at = n;
        end
        n_checks++; if (wr_at !== 3 || en_at !== 3) $display("FAIL midrst_recover: got write %0d en %0d expected 3 3", wr_at, en_at); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        rst_n_s = 1'b0;
        bus.init_done = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus_s.init_done = 1'b0;
        bus_s.wr_req = 1'b0;
        bus_s.rd_req = 1'b0;
        test_reset();
        test_refresh();
        test_write();
        test_read();
        test_priority();
        test_back_to_back();
        test_ref_miss();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
